boot_sequencer: RTL

Controller that loads a bytecode program into the microprocessor's 1024×8 program memory from a byte stream and terminates it with the halt byte. It then enables the microprocessor, watches `running`, and captures `result` when execution ends. It sits between the host or test stream and the microprocessor/memory pair, replacing ad-hoc memory preloading with a cycle-accurate boot/run sequence.

---
 rtl/boot_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a program into CPU memory, appends the halt byte, runs the CPU and captures its result.
// Writes land one cycle after each transfer at one byte per cycle; in_ready is high only while loading.
module boot_sequencer #(
  parameter int          ADDR_W        = 10,
  parameter logic [7:0]  HALT_BYTE     = 8'hFF,
  parameter int          START_TIMEOUT = 16,
  parameter int          RUN_TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_enable,
  input  logic              cpu_running,
  input  logic [7:0]        cpu_result,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [7:0]        result,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TERM  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam int TMAX = (RUN_TIMEOUT > START_TIMEOUT) ? RUN_TIMEOUT : START_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] START_LIM = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] RUN_LIM   = TW'(RUN_TIMEOUT - 1);
  // Top address is reserved for the halt byte.
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'((1 << ADDR_W) - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] timer;
  logic          xfer;
  logic          full;

  assign in_ready   = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_TERM) ||
                      (state == S_START) || (state == S_RUN);
  assign done       = (state == S_DONE);
  assign cpu_enable = (state == S_START) || (state == S_RUN);

  assign xfer = in_valid & in_ready;
  assign full = (load_count == CAP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (xfer) begin
          if (full)         state_nxt = S_ERR;
          else if (in_last) state_nxt = S_TERM;
        end
      end
      S_TERM:  state_nxt = S_START;
      S_START: begin
        if (cpu_running)              state_nxt = S_RUN;
        else if (timer == START_LIM)  state_nxt = S_ERR;
      end
      S_RUN: begin
        if (!cpu_running)             state_nxt = S_DONE;
        else if (timer == RUN_LIM)    state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      error      <= 2'd0;
      result     <= '0;
      load_count <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;

      if (state_nxt != state)
        timer <= '0;
      else if (state == S_START || state == S_RUN)
        timer <= timer + 1'b1;

      if ((state == S_IDLE || state == S_DONE || state == S_ERR) && start) begin
        load_count <= '0;
        error      <= 2'd0;
        result     <= '0;
      end

      if (state == S_LOAD && xfer && !full) begin
        mem_we     <= 1'b1;
        mem_addr   <= load_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        load_count <= load_count + 1'b1;
      end

      if (state == S_TERM) begin
        mem_we    <= 1'b1;
        mem_addr  <= load_count[ADDR_W-1:0];
        mem_wdata <= HALT_BYTE;
      end

      if (state == S_RUN && !cpu_running)
        result <= cpu_result;

      // Error code follows from which state gave up.
      if (state_nxt == S_ERR && state != S_ERR) begin
        case (state)
          S_LOAD:  error <= 2'd1;
          S_START: error <= 2'd2;
          S_RUN:   error <= 2'd3;
          default: error <= 2'd0;
        endcase
      end
    end
  end

endmodule
